// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
// Shared definitions for the pipeline hazard controller:
//   - hazState_t : controller state encoding (RUN, MEM_WAIT, HALT)
//   - REG_ZERO   : architectural x0, which never carries a dependency
//   - DEFAULT_MEM_TIMEOUT : default limit on consecutive memory wait cycles
//   - regMatch() : true when an ID operand depends on the register written in EX
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazState_t;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_MEM_TIMEOUT = 64;

    // x0 is hard-wired to zero, so a write to it can never feed a consumer.
    function automatic logic regMatch(input logic       usesReg,
                                      input logic [4:0] idReg,
                                      input logic [4:0] exReg);
        return usesReg && (exReg != REG_ZERO) && (idReg == exReg);
    endfunction

endpackage

// File: rtl/hazard_counter.sv
// hazard_counter
// Saturating up-counter used for the performance debug counters.
// Ports:
//   clk   : clock
//   clr   : synchronous clear (has priority over inc)
//   inc   : count enable; the value holds at all-ones instead of wrapping
//   count : current count, CNT_W bits
module hazard_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk) begin
        if (clr) begin
            countReg <= '0;
        end else if (inc && (countReg != {CNT_W{1'b1}})) begin
            countReg <= countReg + 1'b1;
        end
    end

    assign count = countReg;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Stall / flush controller for the five-stage pipeline.
// Inputs : clk, rst (synchronous, active high), ID operand fields and use
//          flags (idRS1, idRS2, idUsesRS1, idUsesRS2), the ID/EX load info
//          (exMemRead, exWriteDir), the MEM-stage branch outcome
//          (memBranchTaken) and data memory handshake (memReq, memReady).
// Outputs: pcEn, ifidEn, idexEn, exmemEn register enables; ifidFlush,
//          idexFlush, exmemFlush, memwbFlush bubble inserts; sticky memError
//          timeout flag; saturating stallCount and flushCount.
// Outputs are combinational from state and current inputs; only the state,
// the wait counter, the error flag and the two perf counters are registered.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRS1,
    input  logic [4:0]       idRS2,
    input  logic             idUsesRS1,
    input  logic             idUsesRS2,
    input  logic             exMemRead,
    input  logic [4:0]       exWriteDir,
    input  logic             memBranchTaken,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             idexEn,
    output logic             exmemEn,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemFlush,
    output logic             memwbFlush,
    output logic             memError,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    // Wait count on entry to the last tolerated not-ready cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    // With a limit of one cycle, the very first not-ready cycle already times out.
    localparam bit                HALT_ON_ENTRY = (MEM_TIMEOUT <= 1);

    hazState_t         stateReg, stateNext;
    logic [WAIT_W-1:0] waitCntReg, waitCntNext;
    logic              memErrorReg, memErrorNext;

    logic loadUse;
    logic memStall;     // freeze the pipe for a data memory wait state
    logic applyRun;     // normal branch / load-use rules apply this cycle
    logic halted;
    logic branchFlush;

    assign loadUse = exMemRead &&
                     (regMatch(idUsesRS1, idRS1, exWriteDir) ||
                      regMatch(idUsesRS2, idRS2, exWriteDir));

    always_comb begin
        stateNext    = stateReg;
        waitCntNext  = waitCntReg;
        memErrorNext = memErrorReg;
        memStall     = 1'b0;
        applyRun     = 1'b0;
        halted       = 1'b0;
        unique case (stateReg)
            RUN: begin
                if (memReq && !memReady) begin
                    memStall    = 1'b1;
                    waitCntNext = WAIT_W'(1);
                    if (HALT_ON_ENTRY) begin
                        stateNext    = HALT;
                        memErrorNext = 1'b1;
                    end else begin
                        stateNext = MEM_WAIT;
                    end
                end else begin
                    applyRun = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!memReady) begin
                    memStall    = 1'b1;
                    waitCntNext = waitCntReg + 1'b1;
                    if (waitCntReg >= WAIT_LAST) begin
                        stateNext    = HALT;
                        memErrorNext = 1'b1;
                    end
                end else begin
                    // Release cycle: the access completes, so the pipe moves
                    // and the ordinary hazard rules decide this cycle.
                    applyRun    = 1'b1;
                    stateNext   = RUN;
                    waitCntNext = '0;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_comb begin
        pcEn        = 1'b1;
        ifidEn      = 1'b1;
        idexEn      = 1'b1;
        exmemEn     = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        exmemFlush  = 1'b0;
        memwbFlush  = 1'b0;
        branchFlush = 1'b0;
        if (rst || halted) begin
            pcEn    = 1'b0;
            ifidEn  = 1'b0;
            idexEn  = 1'b0;
            exmemEn = 1'b0;
        end else if (memStall) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexEn     = 1'b0;
            exmemEn    = 1'b0;
            memwbFlush = 1'b1;
        end else if (applyRun && memBranchTaken) begin
            // Squash the three wrong-path instructions; the PC loads the target.
            ifidFlush   = 1'b1;
            idexFlush   = 1'b1;
            exmemFlush  = 1'b1;
            branchFlush = 1'b1;
        end else if (applyRun && loadUse) begin
            // Hold PC and IF/ID, bubble into ID/EX; the load still moves to MEM.
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= RUN;
            waitCntReg  <= '0;
            memErrorReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            waitCntReg  <= waitCntNext;
            memErrorReg <= memErrorNext;
        end
    end

    assign memError = memErrorReg && !rst;

    hazard_counter #(.CNT_W(CNT_W)) stallCounter (
        .clk   (clk),
        .clr   (rst),
        .inc   (!pcEn && !rst),
        .count (stallCount)
    );

    hazard_counter #(.CNT_W(CNT_W)) flushCounter (
        .clk   (clk),
        .clr   (rst),
        .inc   (branchFlush),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Scoreboard bench: each driven cycle pushes its expected outputs and
// counter values; the scenario task pops and compares them.
// dutA uses MEM_TIMEOUT=4, CNT_W=16; dutB shares the inputs with CNT_W=2
// so counter saturation can be observed.
module tb_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] idRS1, idRS2, exWriteDir;
    logic       idUsesRS1, idUsesRS2, exMemRead, memBranchTaken, memReq, memReady;

    logic        pcEn, ifidEn, idexEn, exmemEn;
    logic        ifidFlush, idexFlush, exmemFlush, memwbFlush, memError;
    logic [15:0] stallCount, flushCount;

    logic        pcEnB, ifidEnB, idexEnB, exmemEnB;
    logic        ifidFlushB, idexFlushB, exmemFlushB, memwbFlushB, memErrorB;
    logic [1:0]  stallCountB, flushCountB;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .idRS1(idRS1), .idRS2(idRS2),
        .idUsesRS1(idUsesRS1), .idUsesRS2(idUsesRS2),
        .exMemRead(exMemRead), .exWriteDir(exWriteDir),
        .memBranchTaken(memBranchTaken), .memReq(memReq), .memReady(memReady),
        .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
        .memwbFlush(memwbFlush), .memError(memError),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    hazard_unit #(.MEM_TIMEOUT(64), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .idRS1(idRS1), .idRS2(idRS2),
        .idUsesRS1(idUsesRS1), .idUsesRS2(idUsesRS2),
        .exMemRead(exMemRead), .exWriteDir(exWriteDir),
        .memBranchTaken(memBranchTaken), .memReq(memReq), .memReady(memReady),
        .pcEn(pcEnB), .ifidEn(ifidEnB), .idexEn(idexEnB), .exmemEn(exmemEnB),
        .ifidFlush(ifidFlushB), .idexFlush(idexFlushB), .exmemFlush(exmemFlushB),
        .memwbFlush(memwbFlushB), .memError(memErrorB),
        .stallCount(stallCountB), .flushCount(flushCountB)
    );

    // {pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush, exmemFlush, memwbFlush, memError}
    logic [8:0] outVec;
    assign outVec = {pcEn, ifidEn, idexEn, exmemEn,
                     ifidFlush, idexFlush, exmemFlush, memwbFlush, memError};

    localparam logic [8:0] O_ZERO = 9'b0000_0000_0;
    localparam logic [8:0] O_DEF  = 9'b1111_0000_0;
    localparam logic [8:0] O_LU   = 9'b0011_0100_0;
    localparam logic [8:0] O_BR   = 9'b1111_1110_0;
    localparam logic [8:0] O_MW   = 9'b0000_0001_0;
    localparam logic [8:0] O_HALT = 9'b0000_0000_1;

    typedef struct packed {
        logic       r;
        logic       mr;
        logic [4:0] wd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       br;
        logic       req;
        logic       rdy;
        logic [8:0] outs;
    } stim_t;

    typedef struct packed {
        logic [8:0]  outs;
        logic [15:0] stall;
        logic [15:0] flush;
        logic [1:0]  stallB;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mStall = '0;
    logic [15:0] mFlush = '0;
    logic [1:0]  mStallB = '0;

    function automatic stim_t S(input logic r, input logic mr, input logic [4:0] wd,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic br, input logic req, input logic rdy,
                                input logic [8:0] outs);
        stim_t s;
        s = '{r: r, mr: mr, wd: wd, rs1: rs1, u1: u1, rs2: rs2, u2: u2,
              br: br, req: req, rdy: rdy, outs: outs};
        return s;
    endfunction

    // Drive one cycle of inputs and push what the bench expects for it.
    task automatic apply(input stim_t s);
        exp_t e;
        rst            = s.r;
        exMemRead      = s.mr;
        exWriteDir     = s.wd;
        idRS1          = s.rs1;
        idUsesRS1      = s.u1;
        idRS2          = s.rs2;
        idUsesRS2      = s.u2;
        memBranchTaken = s.br;
        memReq         = s.req;
        memReady       = s.rdy;
        if (s.r) begin
            mStall  = '0;
            mFlush  = '0;
            mStallB = '0;
        end else begin
            if (!s.outs[8]) begin
                mStall = mStall + 16'd1;
                if (mStallB != 2'd3) mStallB = mStallB + 2'd1;
            end
            if (s.outs[4]) mFlush = mFlush + 16'd1;
        end
        e.outs   = s.outs;
        e.stall  = mStall;
        e.flush  = mFlush;
        e.stallB = mStallB;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t t[2];
        exp_t  e;
        t[0] = S(1, 1,5, 5,1, 5,1, 1,1,0, O_ZERO);
        t[1] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        for (int i = 0; i < 2; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL reset[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL reset[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] reset[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_load_use();
        stim_t t[5];
        exp_t  e;
        t[0] = S(0, 1,5, 3,1, 5,1, 0,0,0, O_LU);   // rs2 dependency
        t[1] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);  // bubble now in ID/EX
        t[2] = S(0, 1,7, 7,1, 2,1, 0,0,0, O_LU);   // rs1 dependency
        t[3] = S(0, 0,0, 7,1, 2,1, 0,0,0, O_DEF);
        t[4] = S(0, 1,9, 9,1, 9,1, 0,0,0, O_LU);   // both operands
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL load_use[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL load_use[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] load_use[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_no_hazard();
        stim_t t[4];
        exp_t  e;
        t[0] = S(0, 1,0, 0,1, 0,1, 0,0,0, O_DEF);  // load to x0
        t[1] = S(0, 1,9, 9,0, 4,1, 0,0,0, O_DEF);  // matching rs1 not used
        t[2] = S(0, 0,9, 9,1, 9,1, 0,0,0, O_DEF);  // EX is not a load
        t[3] = S(0, 0,0, 0,0, 0,0, 0,1,1, O_DEF);  // memory ready immediately
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL no_hazard[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL no_hazard[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] no_hazard[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_branch();
        stim_t t[3];
        exp_t  e;
        t[0] = S(0, 1,5, 5,1, 5,1, 1,0,0, O_BR);   // branch wins over load-use
        t[1] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        t[2] = S(0, 0,0, 0,0, 0,0, 1,0,0, O_BR);
        for (int i = 0; i < 3; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL branch[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL branch[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] branch[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_mem_wait();
        stim_t t[12];
        exp_t  e;
        t[0]  = S(1, 0,0, 0,0, 0,0, 0,0,0, O_ZERO);
        t[1]  = S(0, 0,0, 0,0, 0,0, 1,1,0, O_MW);   // memory wait beats branch
        t[2]  = S(0, 1,5, 5,1, 5,1, 1,1,0, O_MW);
        t[3]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[4]  = S(0, 0,0, 0,0, 0,0, 0,1,1, O_DEF);  // release is not a stall
        t[5]  = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        t[6]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[7]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[8]  = S(0, 0,0, 0,0, 0,0, 1,1,1, O_BR);   // release with taken branch
        t[9]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[10] = S(0, 1,6, 6,1, 0,0, 0,1,1, O_LU);   // release with load-use
        t[11] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        for (int i = 0; i < 12; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL mem_wait[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL mem_wait[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] mem_wait[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_timeout();
        stim_t t[13];
        exp_t  e;
        t[0]  = S(1, 0,0, 0,0, 0,0, 0,0,0, O_ZERO);
        t[1]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[2]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[3]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[4]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);   // 4th not-ready cycle
        t[5]  = S(0, 0,0, 0,0, 0,0, 0,1,1, O_HALT); // too late, halted
        t[6]  = S(0, 1,5, 5,1, 0,0, 1,0,0, O_HALT); // halt ignores everything
        t[7]  = S(1, 0,0, 0,0, 0,0, 0,0,0, O_ZERO);
        t[8]  = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        t[9]  = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[10] = S(0, 0,0, 0,0, 0,0, 0,1,0, O_MW);
        t[11] = S(1, 0,0, 0,0, 0,0, 0,1,0, O_ZERO); // reset mid-wait
        t[12] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        for (int i = 0; i < 13; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL timeout[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL timeout[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] timeout[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[4];
        exp_t  e;
        t[0] = S(0, 1,3, 3,1, 0,0, 0,0,0, O_LU);
        t[1] = S(0, 1,4, 0,0, 4,1, 0,0,0, O_LU);
        t[2] = S(0, 0,0, 0,0, 0,0, 1,0,0, O_BR);
        t[3] = S(0, 0,0, 0,0, 0,0, 1,0,0, O_BR);
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL back_to_back[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCount !== e.stall || flushCount !== e.flush) begin
                fails++;
                $display("FAIL back_to_back[%0d] counters got %0d/%0d want %0d/%0d",
                         i, stallCount, flushCount, e.stall, e.flush);
            end
            $display("[TB] back_to_back[%0d] outs=%b stall=%0d flush=%0d", i, outVec, stallCount, flushCount);
        end
    endtask

    task automatic test_saturation();
        stim_t t[11];
        exp_t  e;
        t[0] = S(1, 0,0, 0,0, 0,0, 0,0,0, O_ZERO);
        for (int k = 0; k < 5; k++) begin
            t[1 + 2*k] = S(0, 1,5, 0,0, 5,1, 0,0,0, O_LU);
            t[2 + 2*k] = S(0, 0,0, 0,0, 0,0, 0,0,0, O_DEF);
        end
        for (int i = 0; i < 11; i++) begin
            apply(t[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests++;
            if (outVec !== e.outs) begin
                fails++;
                $display("FAIL saturation[%0d] outs got %b want %b", i, outVec, e.outs);
            end
            @(posedge clk); #1;
            tests++;
            if (stallCountB !== e.stallB || stallCount !== e.stall) begin
                fails++;
                $display("FAIL saturation[%0d] stall got %0d (2-bit %0d) want %0d (2-bit %0d)",
                         i, stallCount, stallCountB, e.stall, e.stallB);
            end
            $display("[TB] saturation[%0d] outs=%b stall=%0d stall2b=%0d", i, outVec, stallCount, stallCountB);
        end
    endtask

    initial begin
        rst = 1'b1; exMemRead = 1'b0; exWriteDir = '0; idRS1 = '0; idRS2 = '0;
        idUsesRS1 = 1'b0; idUsesRS2 = 1'b0; memBranchTaken = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the five-stage RISC-V core. It observes the instruction in ID, the ID/EX register outputs and the MEM-stage memory handshake. From these it drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts load-use bubbles, squashes wrong-path instructions on a taken branch, freezes the pipe on data-memory wait states, and halts on memory timeout. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MEM_TIMEOUT, 64: maximum consecutive wait cycles tolerated in MEM_WAIT before HALT.
- CNT_W, 16: width of the performance counters.

- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- idRS1  in  5  rs1 field of the instruction in ID.
- idRS2  in  5  rs2 field of the instruction in ID.
- idUsesRS1  in  1  ID instruction reads rs1.
- idUsesRS2  in  1  ID instruction reads rs2.
- exMemRead  in  1  ID/EX readMemRead (a load is in EX).
- exWriteDir  in  5  ID/EX readWriteDir.
- memBranchTaken  in  1  branch resolved taken in MEM.
- memReq  in  1  MEM-stage instruction accesses data memory.
- memReady  in  1  data memory completes the access this cycle.
- pcEn  out  1  PC load enable.
- ifidEn, idexEn, exmemEn  out  1 each  pipeline register enables.
- ifidFlush, idexFlush, exmemFlush, memwbFlush  out  1 each  bubble insert. The top level ORs each flush with rst into the register's rst input.
- memError  out  1  sticky memory-timeout flag.
- stallCount  out  CNT_W  cycles with pcEn=0 while not in reset.
- flushCount  out  CNT_W  taken-branch flush events.

## Operation
- States: RUN, MEM_WAIT, HALT. Outputs are combinational from the state and the current inputs (Mealy). State and counters are registered.
- Defaults in RUN: all enables 1, all flushes 0.
- The following conditions are evaluated in RUN in priority order.
  1. **Memory wait** (memReq=1, memReady=0):
     - Drive pcEn=ifidEn=idexEn=exmemEn=0 and memwbFlush=1.
     - Next state is MEM_WAIT; the wait counter loads 1.
     - No bubble or branch flush is applied this cycle.
  2. **Taken branch** (memBranchTaken=1):
     - Drive ifidFlush=idexFlush=exmemFlush=1 and pcEn=1, so the PC loads the branch target.
     - Increment flushCount.
     - A coincident load-use hazard is discarded.
  3. **Load-use hazard**: exMemRead=1, exWriteDir≠0, and (idUsesRS1 and idRS1==exWriteDir, or idUsesRS2 and idRS2==exWriteDir):
     - Drive pcEn=ifidEn=0 and idexFlush=1.
     - exmemEn stays 1, so the load advances into MEM.
- MEM_WAIT:
  - Outputs are as in case 1 while memReady=0.
  - Each such cycle the wait counter increments.
  - When the count reaches MEM_TIMEOUT with memReady still 0, go to HALT and set memError.
  - When memReady=1, outputs follow the RUN rules this same cycle with the memory condition treated as false, and the next state is RUN.
- HALT:
  - All enables 0, all flushes 0.
  - Remains in HALT until rst.
  - memError stays 1.
- Register x0 never creates a hazard.
- Counters saturate at all-ones and never wrap.

## Timing
- rst=1: on the next edge, state←RUN, wait counter←0, stallCount←0, flushCount←0, memError←0.
- While rst=1, outputs are forced: all enables 0, all flushes 0, memError 0.
- Load-use costs exactly 1 bubble cycle. In the following cycle the load is in MEM and the ID/EX register holds a bubble with MemRead=0, so the hazard clears without further state.
- Taken-branch penalty is 3 squashed instructions, applied in one cycle.
- Memory wait:
  - The stall lasts exactly as many cycles as memReady=0.
  - The release cycle is not a stall; stallCount counts only cycles with pcEn=0.
- Timeout: HALT is entered on the edge after the MEM_TIMEOUT-th consecutive not-ready cycle. If memReady=1 arrives in that same cycle, return to RUN instead of HALT.
- rst mid-MEM_WAIT or in HALT: return to RUN on the next edge.

## Structure
- Shared core package holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2);
  - REG_ZERO=5'd0;
  - default MEM_TIMEOUT.
- Natural sub-module: hazard_counter, a saturating CNT_W counter with synchronous clear and increment enable. It is instantiated for stallCount and flushCount; the wait counter stays inline.

## Test plan
- Load-use: exMemRead=1, exWriteDir=5, idRS2=5, idUsesRS2=1 → one cycle with pcEn=0, ifidEn=0, idexFlush=1; stallCount=1; the next cycle is back to defaults.
- x0 / unused operand: exWriteDir=0 with idRS1=0, or matching idRS1 with idUsesRS1=0 → no stall.
- Taken branch coincident with load-use → ifidFlush=idexFlush=exmemFlush=1, pcEn=1; flushCount=1; stallCount unchanged.
- Memory wait: memReq=1, memReady=0 for 3 cycles, then 1 → enables 0 and memwbFlush=1 for 3 cycles; stallCount=3; RUN on the 4th cycle.
- Timeout with MEM_TIMEOUT=4: memReady held 0 → HALT after the 4th cycle, memError=1, all enables 0; rst → RUN, memError=0, counters 0.
- Saturation with CNT_W=2: 5 load-use events → stallCount=3.
